// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data and an occupancy count; 1-cycle read latency.
// Writes while full and reads while empty are dropped, so producers and consumers throttle on full/empty.
module fifo_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic [DATA_WIDTH-1:0]      din,
  output logic [DATA_WIDTH-1:0]      dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // Storage carries no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + AW'(1);
        dout   <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync: reset, fill, overflow, drain, underflow, concurrent traffic across wrap.
module tb_fifo_sync;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic [3:0] count;

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];
  logic [7:0] nxt;
  logic [7:0] exp_d;

  fifo_sync #(.DATA_WIDTH(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs and samples move 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic r, input logic [7:0] d);
    wr_en = w;
    rd_en = r;
    din   = d;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00);
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_dout",  32'(dout),  32'd0);

    // Store 3 words with dout non-zero, then reset asynchronously mid-cycle.
    rst = 1'b1;
    drive(1'b1, 1'b0, 8'h05); step();
    drive(1'b1, 1'b0, 8'h06); step();
    drive(1'b1, 1'b0, 8'h07); step();
    drive(1'b1, 1'b1, 8'h08); step();
    chk("pre_rst_count", 32'(count), 32'd3);
    chk("pre_rst_dout",  32'(dout),  32'h05);
    drive(1'b0, 1'b0, 8'h00);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_empty", 32'(empty), 32'd1);
    chk("async_rst_full",  32'(full),  32'd0);
    chk("async_rst_dout",  32'(dout),  32'd0);
    step();
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'h00); step();
    chk("post_rst_rd_count", 32'(count), 32'd0);
    chk("post_rst_rd_dout",  32'(dout),  32'd0);
    chk("post_rst_rd_empty", 32'(empty), 32'd1);

    // Fill 0x11..0x88.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 8'((i + 1) * 8'h11));
      step();
      chk($sformatf("fill_count%0d", i), 32'(count), 32'(i + 1));
      chk($sformatf("fill_empty%0d", i), 32'(empty), 32'd0);
      chk($sformatf("fill_full%0d", i),  32'(full),  (i == 7) ? 32'd1 : 32'd0);
    end

    // Overflow write is discarded.
    drive(1'b1, 1'b0, 8'hAA); step();
    chk("ovf_count", 32'(count), 32'd8);
    chk("ovf_full",  32'(full),  32'd1);

    // Drain in order.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      step();
      chk($sformatf("drain_dout%0d", i),  32'(dout),  32'((i + 1) * 8'h11));
      chk($sformatf("drain_count%0d", i), 32'(count), 32'(7 - i));
      chk($sformatf("drain_empty%0d", i), 32'(empty), (i == 7) ? 32'd1 : 32'd0);
    end

    // Underflow read leaves everything alone.
    drive(1'b0, 1'b1, 8'h00); step();
    chk("udf_count", 32'(count), 32'd0);
    chk("udf_dout",  32'(dout),  32'h88);

    // Simultaneous request while empty: write only, dout unchanged.
    drive(1'b1, 1'b1, 8'h99); step();
    chk("both_empty_count", 32'(count), 32'd1);
    chk("both_empty_dout",  32'(dout),  32'h88);
    drive(1'b0, 1'b1, 8'h00); step();
    chk("both_empty_rd_dout",  32'(dout),  32'h99);
    chk("both_empty_rd_count", 32'(count), 32'd0);

    // Preload 4, then 12 cycles of simultaneous traffic crossing pointer wrap.
    nxt = 8'h30;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, nxt);
      exp_q.push_back(nxt);
      nxt++;
      step();
    end
    chk("preload_count", 32'(count), 32'd4);
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b1, nxt);
      exp_q.push_back(nxt);
      nxt++;
      exp_d = exp_q.pop_front();
      step();
      chk($sformatf("conc_dout%0d", i),  32'(dout),  32'(exp_d));
      chk($sformatf("conc_count%0d", i), 32'(count), 32'd4);
    end

    // Top up to full, then simultaneous request reads only.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, nxt);
      exp_q.push_back(nxt);
      nxt++;
      step();
    end
    chk("topup_full", 32'(full), 32'd1);
    drive(1'b1, 1'b1, 8'hEE);
    exp_d = exp_q.pop_front();
    step();
    chk("both_full_count", 32'(count), 32'd7);
    chk("both_full_dout",  32'(dout),  32'(exp_d));
    chk("both_full_full",  32'(full),  32'd0);

    // Remaining words come out in order without the dropped 0xEE.
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, 1'b1, 8'h00);
      exp_d = exp_q.pop_front();
      step();
      chk($sformatf("final_dout%0d", i), 32'(dout), 32'(exp_d));
    end
    chk("final_empty", 32'(empty), 32'd1);
    chk("final_count", 32'(count), 32'd0);
    drive(1'b0, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
